// File: rtl/obu_stream_sequencer.sv
// obu_stream_sequencer
//
// Walks a stream of 32-bit bitstream words one OBU at a time. The sequencer
// starts the external header parser and lends it the input FIFO until the
// parser reports the payload size. It then forwards the payload as
// left-aligned beats of 1..4 bytes and returns to IDLE for the next OBU. The
// byte offset of the header or payload inside the current word is carried
// across OBUs, because a payload may end mid-word.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   enable            permits starting a new OBU from IDLE
//   in_data/in_valid  FIFO head word (byte 0 at [31:24]) and its valid flag
//   in_pop            consume the FIFO head this cycle
//   hdr_start         one-cycle start pulse to the header parser
//   hdr_offset        byte offset in the current word where the header begins
//   hdr_avail         in_valid, gated to the header phase
//   hdr_pop           header parser word-consume request
//   hdr_done          header complete; size/pad fields valid this cycle
//   hdr_obu_size      payload size in bytes
//   hdr_pad           current word only partly read by the header
//   hdr_pad_len       unread bits in that word (8,16,24,32)
//   cfg_max_size      largest legal payload size
//   out_data          payload bytes, left aligned, unused lanes zero
//   out_bytes         valid bytes in out_data (1..4)
//   out_valid/ready   payload handshake
//   out_last          beat carries the final payload byte of the OBU
//   err               sticky oversize error
//   obu_count         completed OBUs, wraps
module obu_stream_sequencer #(
    parameter int unsigned PARSER_DATA_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH        = 56,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [PARSER_DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_pop,
    output logic                         hdr_start,
    output logic [1:0]                   hdr_offset,
    output logic                         hdr_avail,
    input  logic                         hdr_pop,
    input  logic                         hdr_done,
    input  logic [SIZE_WIDTH-1:0]        hdr_obu_size,
    input  logic                         hdr_pad,
    input  logic [5:0]                   hdr_pad_len,
    input  logic [31:0]                  cfg_max_size,
    output logic [PARSER_DATA_WIDTH-1:0] out_data,
    output logic [2:0]                   out_bytes,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         err,
    output logic [COUNT_WIDTH-1:0]       obu_count
);

    localparam int unsigned CMP_WIDTH = (SIZE_WIDTH > 32) ? SIZE_WIDTH : 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               offset_q, offset_d;
    logic [SIZE_WIDTH-1:0]    remaining_q, remaining_d;
    logic                     err_q, err_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     hdr_start_q, hdr_start_d;

    logic [2:0]               avail;
    logic [2:0]               beat_bytes;
    logic [2:0]               beat_end;
    logic [2:0]               pad_bytes;
    logic [1:0]               hdr_off_new;
    logic [SIZE_WIDTH-1:0]    avail_ext;
    logic [SIZE_WIDTH-1:0]    beat_ext;
    logic [PARSER_DATA_WIDTH-1:0] shifted;
    logic [PARSER_DATA_WIDTH-1:0] masked;
    logic                     oversize;
    logic                     beat_is_last;
    logic                     unused_pad_bits;

    // Only whole-byte pad lengths occur; the sub-byte bits carry no information.
    assign unused_pad_bits = ^hdr_pad_len[2:0];

    // Beat geometry: bytes left in the current word, clipped to the bytes
    // left in the OBU.
    assign avail        = 3'd4 - {1'b0, offset_q};
    assign avail_ext    = SIZE_WIDTH'(avail);
    assign beat_bytes   = (remaining_q < avail_ext) ? remaining_q[2:0] : avail;
    assign beat_ext     = SIZE_WIDTH'(beat_bytes);
    assign beat_end     = {1'b0, offset_q} + beat_bytes;
    assign beat_is_last = (remaining_q == beat_ext);
    assign shifted      = in_data << {offset_q, 3'b000};

    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < 32'(beat_bytes)) begin
                masked[PARSER_DATA_WIDTH-1-8*i -: 8] = shifted[PARSER_DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    // A fully unread word (pad_len 32) puts the payload at offset 0, not 4.
    assign pad_bytes   = 3'd4 - hdr_pad_len[5:3];
    assign hdr_off_new = hdr_pad ? pad_bytes[1:0] : 2'd0;

    assign oversize = CMP_WIDTH'(hdr_obu_size) > CMP_WIDTH'(cfg_max_size);

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        count_d     = count_q;
        hdr_start_d = 1'b0;
        in_pop      = 1'b0;
        hdr_avail   = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_bytes   = '0;
        out_last    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && in_valid) begin
                    state_d     = S_HDR;
                    hdr_start_d = 1'b1;
                end
            end

            S_HDR: begin
                hdr_avail = in_valid;
                in_pop    = hdr_pop && in_valid;
                if (hdr_done) begin
                    offset_d    = hdr_off_new;
                    remaining_d = hdr_obu_size;
                    if (oversize) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (hdr_obu_size == '0) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                out_valid = in_valid;
                out_bytes = beat_bytes;
                out_data  = masked;
                out_last  = in_valid && beat_is_last;
                if (in_valid && out_ready) begin
                    remaining_d = remaining_q - beat_ext;
                    offset_d    = beat_end[1:0];
                    in_pop      = (beat_end == 3'd4);
                    if (beat_is_last) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                        state_d = S_IDLE;
                    end
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            count_q     <= '0;
            hdr_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            count_q     <= count_d;
            hdr_start_q <= hdr_start_d;
        end
    end

    assign hdr_start  = hdr_start_q;
    assign hdr_offset = offset_q;
    assign err        = err_q;
    assign obu_count  = count_q;

endmodule

// File: tb/tb_obu_stream_sequencer.sv
module tb_obu_stream_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, in_valid, hdr_pop, hdr_done, hdr_pad, out_ready;
    logic [31:0] in_data, cfg_max_size;
    logic [55:0] hdr_obu_size;
    logic [5:0]  hdr_pad_len;

    logic        in_pop, hdr_start, hdr_avail, out_valid, out_last, err;
    logic [1:0]  hdr_offset;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic [15:0] obu_count;

    logic        s_in_pop, s_hdr_start, s_hdr_avail, s_out_valid, s_out_last, s_err;
    logic [1:0]  s_hdr_offset;
    logic [31:0] s_out_data;
    logic [2:0]  s_out_bytes;
    logic [3:0]  s_count;

    obu_stream_sequencer #(.PARSER_DATA_WIDTH(32), .SIZE_WIDTH(56), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_pop(in_pop), .hdr_start(hdr_start), .hdr_offset(hdr_offset), .hdr_avail(hdr_avail),
        .hdr_pop(hdr_pop), .hdr_done(hdr_done), .hdr_obu_size(hdr_obu_size), .hdr_pad(hdr_pad),
        .hdr_pad_len(hdr_pad_len), .cfg_max_size(cfg_max_size), .out_data(out_data),
        .out_bytes(out_bytes), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .err(err), .obu_count(obu_count)
    );

    // Narrow-counter twin used to observe the counter wrap in few cycles.
    obu_stream_sequencer #(.PARSER_DATA_WIDTH(32), .SIZE_WIDTH(56), .COUNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_pop(s_in_pop), .hdr_start(s_hdr_start), .hdr_offset(s_hdr_offset), .hdr_avail(s_hdr_avail),
        .hdr_pop(hdr_pop), .hdr_done(hdr_done), .hdr_obu_size(hdr_obu_size), .hdr_pad(hdr_pad),
        .hdr_pad_len(hdr_pad_len), .cfg_max_size(cfg_max_size), .out_data(s_out_data),
        .out_bytes(s_out_bytes), .out_valid(s_out_valid), .out_ready(out_ready), .out_last(s_out_last),
        .err(s_err), .obu_count(s_count)
    );

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic quiet;
        enable = 0; in_valid = 0; in_data = '0; hdr_pop = 0; hdr_done = 0;
        hdr_pad = 0; hdr_pad_len = '0; hdr_obu_size = '0; out_ready = 0;
    endtask

    task automatic do_reset;
        quiet();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Drives IDLE -> HDR; returns in the first HDR cycle.
    task automatic start_obu(input logic [31:0] w);
        enable = 1; in_valid = 1; in_data = w;
        tick();
        enable = 0;
    endtask

    typedef struct {
        logic        pad;
        logic [5:0]  pad_len;
        logic [55:0] size;
        logic [31:0] w0, w1;
        logic [31:0] d0; logic [2:0] n0; logic l0, p0;
        logic [31:0] d1; logic [2:0] n1; logic l1, p1;
        logic [1:0]  off;
    } vec_t;

    vec_t vecs [7];

    logic [7:0] mem [16384];

    function automatic logic [31:0] word_at(input int idx);
        return {mem[4*idx], mem[4*idx+1], mem[4*idx+2], mem[4*idx+3]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ptr, h, rem, cnt, phase, pops_left, n;
        logic first, r_pad;
        logic [5:0] r_len;
        int r_size;
        logic [31:0] e;

        //             pad  len    size  w0            w1            d0            n0 l0 p0  d1            n1 l1 p1 off
        vecs[0] = '{1'b0, 6'd0,  56'd6, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hA1A2A3A4, 3'd4, 1'b0, 1'b1, 32'hB1B20000, 3'd2, 1'b1, 1'b0, 2'd2};
        vecs[1] = '{1'b1, 6'd16, 56'd2, 32'hC1C2C3C4, 32'h0,        32'hC3C40000, 3'd2, 1'b1, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 6'd8,  56'd5, 32'hD1D2D3D4, 32'hE1E2E3E4, 32'hD4000000, 3'd1, 1'b0, 1'b1, 32'hE1E2E3E4, 3'd4, 1'b1, 1'b1, 2'd0};
        vecs[3] = '{1'b1, 6'd32, 56'd3, 32'hF1F2F3F4, 32'h0,        32'hF1F2F300, 3'd3, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 2'd3};
        vecs[4] = '{1'b1, 6'd24, 56'd1, 32'h11223344, 32'h0,        32'h22000000, 3'd1, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 2'd2};
        vecs[5] = '{1'b0, 6'd0,  56'd4, 32'h55667788, 32'h0,        32'h55667788, 3'd4, 1'b1, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 2'd0};
        vecs[6] = '{1'b1, 6'd16, 56'd0, 32'h99AABBCC, 32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 2'd2};

        rst = 0;
        cfg_max_size = 32'd64;
        do_reset();
        settle();
        chk("rst_count", obu_count, 0);
        chk("rst_err", err, 0);
        chk("rst_start", hdr_start, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_offset", hdr_offset, 0);

        // ---------------- table-driven single-OBU vectors ----------------
        for (int r = 0; r < 7; r++) begin
            vec_t v;
            v = vecs[r];
            do_reset();
            start_obu(v.pad ? v.w0 : 32'h5A5A5A5A);
            hdr_pop = !v.pad; hdr_done = 1; hdr_pad = v.pad; hdr_pad_len = v.pad_len;
            hdr_obu_size = v.size;
            settle();
            chk($sformatf("v%0d_start", r), hdr_start, 1);
            chk($sformatf("v%0d_hdr_pop", r), in_pop, !v.pad);
            chk($sformatf("v%0d_hdr_valid", r), out_valid, 0);
            tick();
            hdr_done = 0; hdr_pop = 0;
            in_data = v.w0; out_ready = 1;
            settle();
            if (v.n0 == 0) begin
                chk($sformatf("v%0d_novalid", r), out_valid, 0);
            end else begin
                chk($sformatf("v%0d_b0_valid", r), out_valid, 1);
                chk($sformatf("v%0d_b0_data", r), out_data, v.d0);
                chk($sformatf("v%0d_b0_bytes", r), out_bytes, v.n0);
                chk($sformatf("v%0d_b0_last", r), out_last, v.l0);
                chk($sformatf("v%0d_b0_pop", r), in_pop, v.p0);
            end
            tick();
            in_data = v.p0 ? v.w1 : v.w0;
            if (v.n1 != 0) begin
                settle();
                chk($sformatf("v%0d_b1_valid", r), out_valid, 1);
                chk($sformatf("v%0d_b1_data", r), out_data, v.d1);
                chk($sformatf("v%0d_b1_bytes", r), out_bytes, v.n1);
                chk($sformatf("v%0d_b1_last", r), out_last, v.l1);
                chk($sformatf("v%0d_b1_pop", r), in_pop, v.p1);
                tick();
            end
            settle();
            chk($sformatf("v%0d_end_valid", r), out_valid, 0);
            chk($sformatf("v%0d_end_offset", r), hdr_offset, v.off);
            chk($sformatf("v%0d_end_count", r), obu_count, 1);
        end

        // ---------------- size 0: back to IDLE, restart gating ----------------
        do_reset();
        start_obu(32'h01020304);
        hdr_done = 1; hdr_obu_size = 0;
        tick();
        hdr_done = 0;
        settle();
        chk("z_count", obu_count, 1);
        chk("z_valid", out_valid, 0);
        enable = 0; in_valid = 1;
        tick(); settle();
        chk("z_no_start_en0", hdr_start, 0);
        enable = 1; in_valid = 0;
        tick(); settle();
        chk("z_no_start_v0", hdr_start, 0);
        enable = 1; in_valid = 1;
        tick(); settle();
        chk("z_start", hdr_start, 1);
        enable = 0;
        tick(); settle();
        chk("z_start_once", hdr_start, 0);

        // ---------------- oversize error, boundary size == max ----------------
        do_reset();
        start_obu(32'h01020304);
        hdr_done = 1; hdr_obu_size = 100; hdr_pop = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            enable = 1; in_valid = 1; hdr_pop = 1; out_ready = 1; hdr_done = 1; hdr_obu_size = 3;
            settle();
            chk("e_err", err, 1);
            chk("e_pop", in_pop, 0);
            chk("e_valid", out_valid, 0);
            chk("e_avail", hdr_avail, 0);
            chk("e_start", hdr_start, 0);
            tick();
        end
        do_reset();
        settle();
        chk("e_cleared", err, 0);
        start_obu(32'h01020304);
        hdr_done = 1; hdr_obu_size = 64;
        tick();
        hdr_done = 0; in_valid = 1;
        settle();
        chk("e_max_ok_err", err, 0);
        chk("e_max_ok_valid", out_valid, 1);

        // ---------------- backpressure and input stall ----------------
        do_reset();
        start_obu(32'h5A5A5A5A);
        hdr_done = 1; hdr_obu_size = 12; hdr_pop = 1;
        tick();
        hdr_done = 0; hdr_pop = 0; in_data = 32'h01020304; out_ready = 1;
        settle();
        chk("bp_b0_data", out_data, 32'h01020304);
        chk("bp_b0_pop", in_pop, 1);
        tick();
        in_data = 32'h11121314; out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 32'h11121314);
            chk("bp_hold_bytes", out_bytes, 4);
            chk("bp_hold_last", out_last, 0);
            chk("bp_hold_pop", in_pop, 0);
            tick();
        end
        in_valid = 0; out_ready = 1;
        settle();
        chk("bp_stall_valid", out_valid, 0);
        chk("bp_stall_pop", in_pop, 0);
        tick();
        in_valid = 1;
        settle();
        chk("bp_b1_last", out_last, 0);
        chk("bp_b1_pop", in_pop, 1);
        tick();
        in_data = 32'h21222324;
        settle();
        chk("bp_b2_data", out_data, 32'h21222324);
        chk("bp_b2_last", out_last, 1);
        tick();
        settle();
        chk("bp_count", obu_count, 1);

        // ---------------- reset mid-payload ----------------
        do_reset();
        start_obu(32'h31323334);
        hdr_done = 1; hdr_obu_size = 10; hdr_pad = 1; hdr_pad_len = 24;
        tick();
        hdr_done = 0; out_ready = 1; rst = 1;
        settle();
        chk("mr_pre_valid", out_valid, 1);
        chk("mr_pre_bytes", out_bytes, 3);
        tick();
        rst = 0;
        settle();
        chk("mr_valid", out_valid, 0);
        chk("mr_pop", in_pop, 0);
        chk("mr_data", out_data, 0);
        chk("mr_bytes", out_bytes, 0);
        chk("mr_last", out_last, 0);
        chk("mr_start", hdr_start, 0);
        chk("mr_count", obu_count, 0);
        chk("mr_offset", hdr_offset, 0);

        // ---------------- counter wrap (4-bit twin) and stray hdr_done ----------------
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            start_obu(32'h0);
            hdr_done = 1; hdr_obu_size = 0;
            tick();
            hdr_done = 0;
            if (k == 15) begin
                settle();
                chk("wrap_pre", s_count, 15);
            end
        end
        settle();
        chk("wrap_small", s_count, 0);
        chk("wrap_wide", obu_count, 16);
        in_valid = 0; hdr_done = 1; hdr_obu_size = 0;
        tick();
        hdr_done = 0;
        settle();
        chk("stray_done", obu_count, 16);

        // ---------------- randomized run against a byte-stream model ----------------
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        do_reset();
        cfg_max_size = 32;
        ptr = 0; h = 0; cnt = 0; phase = 0; first = 0; pops_left = 0;
        rem = 0; r_pad = 0; r_len = 8; r_size = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = in_valid ? word_at(h) : $urandom;
            enable    = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (phase == 1) begin
                hdr_pop      = (pops_left > 0);
                hdr_done     = (pops_left == 0) && ($urandom_range(0, 1) != 0);
                hdr_obu_size = 56'(r_size);
                hdr_pad      = r_pad;
                hdr_pad_len  = r_len;
            end else begin
                hdr_pop      = $urandom_range(0, 1) != 0;
                hdr_done     = $urandom_range(0, 1) != 0;
                hdr_obu_size = 0;
                hdr_pad      = 0;
                hdr_pad_len  = 8;
            end
            settle();
            chk("r_count", obu_count, 16'(cnt));
            chk("r_small_count", s_count, cnt % 16);
            chk("r_err", err, 0);
            if (phase == 0) begin
                chk("r_idle_start", hdr_start, 0);
                chk("r_idle_pop", in_pop, 0);
                chk("r_idle_valid", out_valid, 0);
                chk("r_idle_avail", hdr_avail, 0);
            end else if (phase == 1) begin
                chk("r_hdr_start", hdr_start, first);
                if (first) chk("r_hdr_offset", hdr_offset, ptr % 4);
                chk("r_hdr_avail", hdr_avail, in_valid);
                chk("r_hdr_pop", in_pop, hdr_pop && in_valid);
                chk("r_hdr_valid", out_valid, 0);
            end else begin
                n = 4 - (ptr % 4);
                if (rem < n) n = rem;
                e = '0;
                for (int i = 0; i < n; i++) e[31-8*i -: 8] = mem[ptr+i];
                chk("r_pl_valid", out_valid, in_valid);
                chk("r_pl_start", hdr_start, 0);
                if (in_valid) begin
                    chk("r_pl_data", out_data, e);
                    chk("r_pl_bytes", out_bytes, n);
                    chk("r_pl_last", out_last, rem == n);
                    chk("r_pl_pop", in_pop, out_ready && ((ptr % 4) + n == 4));
                end else begin
                    chk("r_pl_pop_idle", in_pop, 0);
                end
            end
            if (phase == 0) begin
                if (enable && in_valid) begin
                    phase = 1; first = 1;
                    pops_left = $urandom_range(1, 2);
                    r_pad  = $urandom_range(0, 1) != 0;
                    r_len  = 6'(8 * $urandom_range(1, 4));
                    r_size = $urandom_range(0, 32);
                end
            end else if (phase == 1) begin
                first = 0;
                if (hdr_pop && in_valid) begin
                    h++;
                    pops_left--;
                end
                if (hdr_done) begin
                    ptr = h * 4 + (r_pad ? (4 - int'(r_len) / 8) % 4 : 0);
                    rem = r_size;
                    if (rem == 0) begin
                        cnt++;
                        phase = 0;
                    end else begin
                        phase = 2;
                    end
                end
            end else if (in_valid && out_ready) begin
                ptr += n;
                rem -= n;
                if (ptr % 4 == 0) h++;
                if (rem == 0) begin
                    cnt++;
                    phase = 0;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/obu_stream_sequencer.md
OBU_STREAM_SEQUENCER -- requirements
Module: obu_stream_sequencer

Interface
REQ-001 Parameter PARSER_DATA_WIDTH, default 32, input word width in bits; SHALL be 32 (4 bytes, byte 0 = bits [31:24]).
REQ-002 Parameter SIZE_WIDTH, default 56, width of OBU size and the remaining-byte counter.
REQ-003 Parameter COUNT_WIDTH, default 16, width of the OBU counter.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  permits starting a new OBU from IDLE.
REQ-007 in_data  input  32  current bitstream word at FIFO head.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_pop  output  1  consume FIFO head this cycle.
REQ-010 hdr_start  output  1  one-cycle start pulse to header parser.
REQ-011 hdr_offset  output  2  byte offset in current word where header begins; held during HDR.
REQ-012 hdr_avail  output  1  in_valid gated to HDR state.
REQ-013 hdr_pop  input  1  header parser word-consume request.
REQ-014 hdr_done  input  1  header complete; hdr_obu_size/hdr_pad/hdr_pad_len valid this cycle.
REQ-015 hdr_obu_size  input  SIZE_WIDTH  payload bytes.
REQ-016 hdr_pad / hdr_pad_len  input  1 / 6  current word partly unread / unread bits (8,16,24,32).
REQ-017 cfg_max_size  input  32  maximum legal payload size, zero-extended.
REQ-018 out_data  output  32  payload bytes left-aligned (first byte at [31:24]), unused lanes zero.
REQ-019 out_bytes  output  3  valid bytes in out_data, 1..4.
REQ-020 out_valid / out_ready  output / input  1 / 1  payload handshake; transfer when both high.
REQ-021 out_last  output  1  beat carries final payload byte of the OBU.
REQ-022 err  output  1  sticky oversize error.
REQ-023 obu_count  output  COUNT_WIDTH  completed OBUs, wraps modulo 2^COUNT_WIDTH.

Function
REQ-024 States IDLE, HDR, PAYLOAD, ERR; encoding free.
REQ-025 IDLE: when enable && in_valid, next state HDR and hdr_start registered high for exactly the first HDR cycle.
REQ-026 HDR: in_pop = hdr_pop && in_valid; hdr_avail = in_valid; payload outputs idle.
REQ-027 On hdr_done: offset <= (hdr_pad ? 4 - hdr_pad_len[5:3] : 0) mod 4; remaining <= hdr_obu_size.
REQ-028 On hdr_done with hdr_obu_size > cfg_max_size: err <= 1, state ERR; takes priority over other transitions.
REQ-029 On hdr_done with hdr_obu_size == 0: obu_count increments, state IDLE, no payload beat.
REQ-030 Otherwise on hdr_done: state PAYLOAD.
REQ-031 PAYLOAD: out_valid = in_valid; avail = 4 - offset; out_bytes = min(avail, remaining); out_data = in_data << 8*offset with lanes beyond out_bytes zeroed.
REQ-032 out_last = out_valid && (remaining == out_bytes).
REQ-033 On transfer: remaining -= out_bytes; offset <= (offset + out_bytes) mod 4; in_pop = 1 iff offset + out_bytes == 4.
REQ-034 On last transfer: obu_count increments; state IDLE; residual offset retained and drives hdr_offset of next OBU.
REQ-035 out_data/out_bytes/out_last SHALL stay stable while out_valid && !out_ready.
REQ-036 in_pop SHALL never assert with in_valid low; never in IDLE or ERR.
REQ-037 ERR: all handshake outputs low; exits only via rst.
REQ-038 hdr_done outside HDR SHALL be ignored.

Reset
REQ-039 rst SHALL force, next edge: state IDLE, offset 0, remaining 0, err 0, obu_count 0, hdr_start 0, in_pop 0, out_valid 0, out_last 0, out_data 0, out_bytes 0; valid mid-HDR or mid-PAYLOAD, discarding the OBU in progress.

Verification
REQ-040 Header ends at word boundary (hdr_pad=0), size 6, words 0xA1A2A3A4,0xB1B2B3B4 -> beats (0xA1A2A3A4,4,last=0),(0xB1B2_0000,2,last=1); offset 2; obu_count 1; two pops.
REQ-041 hdr_pad=1, pad_len=16, size 2 -> single beat of current word's bytes 2..3, 2 bytes, last=1, one pop, offset 0.
REQ-042 size 0 -> no out_valid, obu_count +1, IDLE next cycle, next hdr_start only once enable && in_valid.
REQ-043 size 100, cfg_max_size 64 -> err=1, state ERR, no pops/beats until rst.
REQ-044 out_ready low 3 cycles mid-payload -> outputs held, no in_pop, remaining unchanged; in_valid low -> out_valid low.
REQ-045 rst pulsed mid-PAYLOAD with remaining 10 -> all outputs at reset values next cycle; obu_count 0xFFFF wraps to 0 on next completion.
